// File: rtl/game_prbs_draw_pkg.sv
// Shared types and helpers for the game PRBS draw block.
//  state_e   : draw FSM states
//  TAPS_Wn   : known-good Fibonacci feedback masks for common widths
//  lfsr_next : one Fibonacci shift, result masked to w bits
package game_prbs_draw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam int unsigned MAX_W = 32;

   // Feedback masks: bit i set => lfsr[i] joins the XOR
   localparam logic [MAX_W-1:0] TAPS_W4  = 32'h0000_000C;  // x^4+x^3+1
   localparam logic [MAX_W-1:0] TAPS_W6  = 32'h0000_0030;  // x^6+x^5+1
   localparam logic [MAX_W-1:0] TAPS_W8  = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
   localparam logic [MAX_W-1:0] TAPS_W16 = 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
   localparam logic [MAX_W-1:0] TAPS_W32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1

   // Shift left by one, feeding the parity of the tapped bits into bit 0
   function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int unsigned      w);
      logic             fb;
      logic [MAX_W-1:0] mask;
      fb   = ^(state & taps);
      mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return {state[MAX_W-2:0], fb} & mask;
   endfunction

endpackage

// File: rtl/game_prbs_draw_lfsr_core.sv
// Fibonacci LFSR state register with load and step enables.
//  clock, rst_n : clock, async active-low reset (state -> DEFAULT_SEED)
//  load_i       : load seed_i (zero seed replaced by DEFAULT_SEED); wins over step_i
//  seed_i       : seed value
//  step_i       : advance one shift
//  state_o      : current LFSR state, never zero
module game_lfsr_core
   import game_prbs_draw_pkg::*;
#(
   parameter int unsigned    W            = 6,
   parameter logic [W-1:0]   TAPS         = 6'b110000,
   parameter logic [W-1:0]   DEFAULT_SEED = 6'b000001
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] seed_i,
   input  logic         step_i,
   output logic [W-1:0] state_o
);

   logic [W-1:0] state_q, state_d, stepped;

   // Next shift value; an all-zero result would lock up, so reseed instead
   always_comb begin
      stepped = W'(lfsr_next(MAX_W'(state_q), MAX_W'(TAPS), W));
      if (stepped == '0) stepped = DEFAULT_SEED;
   end

   always_comb begin
      state_d = state_q;
      if (load_i)      state_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
      else if (step_i) state_d = stepped;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= DEFAULT_SEED;
      else        state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/game_prbs_draw.sv
// Draw-handshake random source: each accepted request returns one value in
// [0, limit) by rejection-sampling LFSR candidates, with a bounded number of
// retries and a deterministic folding fallback.
//  clock, rst_n          : clock, async active-low reset
//  new_game, seed        : reload LFSR and abort any draw in flight
//  req_valid/req_ready   : draw request handshake (ready only in IDLE)
//  limit                 : range bound, sampled at request accept (0 = full range)
//  rsp_valid/rsp_ready   : result handshake
//  rsp_data, fallback    : drawn value; fallback marks the folded-candidate path
module game_prbs_draw
   import game_prbs_draw_pkg::*;
#(
   parameter int unsigned  W            = 6,
   parameter logic [W-1:0] TAPS         = 6'b110000,
   parameter logic [W-1:0] DEFAULT_SEED = 6'b000001,
   parameter int unsigned  STEPS        = W,
   parameter int unsigned  MAX_TRIES    = 4
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         new_game,
   input  logic [W-1:0] seed,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] limit,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         fallback
);

   localparam int unsigned SCW = (STEPS < 2) ? 1 : $clog2(STEPS);
   localparam int unsigned TCW = $clog2(MAX_TRIES + 1);

   state_e         state_q, state_d;
   logic [SCW-1:0] step_cnt_q, step_cnt_d;
   logic [TCW-1:0] try_q, try_d, try_inc;
   logic [W-1:0]   lim_q, lim_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           fallback_q, fallback_d;
   logic           step_en, load_en;
   logic [W-1:0]   lfsr_state;
   logic [W-1:0]   lim_m1, fold_mask, masked, fold_val;

   game_lfsr_core #(
      .W            (W),
      .TAPS         (TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clock   (clock),
      .rst_n   (rst_n),
      .load_i  (load_en),
      .seed_i  (seed),
      .step_i  (step_en),
      .state_o (lfsr_state)
   );

   // Fallback fold: smearing the leading one of lim-1 downward gives 2^clog2(lim)-1,
   // so the masked candidate is < 2*lim and one conditional subtract brings it below lim
   always_comb begin
      lim_m1 = lim_q - W'(1);
      fold_mask[W-1] = lim_m1[W-1];
      for (int i = int'(W) - 2; i >= 0; i--) begin
         fold_mask[i] = fold_mask[i+1] | lim_m1[i];
      end
      masked   = lfsr_state & fold_mask;
      fold_val = (masked >= lim_q) ? (masked - lim_q) : masked;
   end

   assign try_inc   = try_q + TCW'(1);
   assign req_ready = (state_q == IDLE) && !new_game;

   // Next-state and register-input logic
   always_comb begin
      state_d     = state_q;
      step_cnt_d  = step_cnt_q;
      try_d       = try_q;
      lim_d       = lim_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      fallback_d  = fallback_q;
      step_en     = 1'b0;
      load_en     = 1'b0;

      if (new_game) begin
         load_en     = 1'b1;
         state_d     = IDLE;
         rsp_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  lim_d      = limit;
                  step_cnt_d = '0;
                  try_d      = '0;
                  state_d    = STEP;
               end
            end
            STEP: begin
               step_en    = 1'b1;
               step_cnt_d = step_cnt_q + SCW'(1);
               if (step_cnt_q == SCW'(STEPS - 1)) state_d = CHECK;
            end
            CHECK: begin
               if (lim_q == '0 || lfsr_state < lim_q || lim_q == W'(1)) begin
                  rsp_data_d  = (lim_q == W'(1)) ? '0 : lfsr_state;
                  fallback_d  = 1'b0;
                  rsp_valid_d = 1'b1;
                  state_d     = HOLD;
               end else if (try_inc < TCW'(MAX_TRIES)) begin
                  try_d      = try_inc;
                  step_cnt_d = '0;
                  state_d    = STEP;
               end else begin
                  rsp_data_d  = fold_val;
                  fallback_d  = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = HOLD;
               end
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_cnt_q  <= '0;
         try_q       <= '0;
         lim_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         fallback_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_cnt_q  <= step_cnt_d;
         try_q       <= try_d;
         lim_q       <= lim_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         fallback_q  <= fallback_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign fallback  = fallback_q;

endmodule

// File: tb/tb_game_prbs_draw.sv
// Scoreboard bench for game_prbs_draw (W=6, STEPS=6, MAX_TRIES=4).
module tb_game_prbs_draw;

   localparam int W         = 6;
   localparam int STEPS     = 6;
   localparam int MAX_TRIES = 4;
   localparam int LAT1      = STEPS + 1;
   localparam int TAPS      = 6'b110000;

   logic         clock;
   logic         rst_n;
   logic         new_game;
   logic [W-1:0] seed;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] limit;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         fallback;

   game_prbs_draw #(
      .W            (W),
      .TAPS         (6'b110000),
      .DEFAULT_SEED (6'b000001),
      .STEPS        (STEPS),
      .MAX_TRIES    (MAX_TRIES)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .new_game  (new_game),
      .seed      (seed),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .limit     (limit),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .fallback  (fallback)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int data;
      bit fb;
      int lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   nchk = 0;
   int   nerr = 0;
   int   m_lfsr = 1;
   int   last_exp_data = 0;
   int   last_fb = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: one shift of the polynomial, zero state reseeds to 1
   function automatic int lfsr_step(input int s);
      int fb;
      int n;
      fb = ^(s & TAPS);
      n  = ((s << 1) | fb) & 63;
      return (n == 0) ? 1 : n;
   endfunction

   // Reference model of one full draw from the current model state
   function automatic void model_draw(input int lim, output int data, output bit fb, output int tries);
      int cand;
      int m;
      data  = 0;
      fb    = 1'b0;
      tries = 0;
      for (int t = 1; t <= MAX_TRIES; t++) begin
         for (int i = 0; i < STEPS; i++) m_lfsr = lfsr_step(m_lfsr);
         cand  = m_lfsr;
         tries = t;
         if (lim == 0)       begin data = cand; return; end
         if (lim == 1)       begin data = 0;    return; end
         if (cand < lim)     begin data = cand; return; end
         if (t == MAX_TRIES) begin
            m    = cand % (1 << $clog2(lim));
            data = (m >= lim) ? m - lim : m;
            fb   = 1'b1;
            return;
         end
      end
   endfunction

   // Monitor: compare each newly presented result against the scoreboard head
   bit seen = 1'b0;
   always @(negedge clock) begin
      if (rst_n && rsp_valid && !seen) begin
         exp_t e;
         seen = 1'b1;
         if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_rsp: got data %0d with no draw pending", rsp_data);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("fallback", 32'(fallback), 32'(e.fb));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
         last_fb = int'(fallback);
      end else if (!rsp_valid) begin
         seen = 1'b0;
      end
   end

   task automatic do_new_game(input int s);
      @(negedge clock);
      new_game = 1'b1;
      seed     = W'(s);
      #1 chk("req_ready_newgame", 32'(req_ready), 32'd0);
      @(posedge clock);
      #1 new_game = 1'b0;
      seed   = W'($urandom);
      m_lfsr = (s == 0) ? 1 : s;
   endtask

   task automatic draw(input int lim, input bit expect_rsp);
      int d;
      int t;
      bit f;
      int n;
      @(negedge clock);
      limit     = W'(lim);
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         nchk++;
         nerr++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
         req_valid = 1'b0;
         return;
      end
      if (expect_rsp) begin
         model_draw(lim, d, f, t);
         last_exp_data = d;
         sb.push_back('{data: d, fb: f, lat: t * LAT1, acc: cyc + 1});
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      limit = W'($urandom);
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < MAX_TRIES * LAT1 + 5) begin
         @(negedge clock);
         n++;
      end
      if (!rsp_valid) begin
         nchk++;
         nerr++;
         $display("FAIL rsp_timeout: got rsp_valid 0 expected 1");
      end
   endtask

   task automatic consume(input int rdly, output int d);
      wait_rsp();
      repeat (rdly) @(negedge clock);
      d = int'(rsp_data);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int fseed;
      int fd;
      int ft;
      bit ff;
      int save;

      rst_n = 1'b0; new_game = 1'b0; seed = '0; req_valid = 1'b0;
      limit = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      m_lfsr = 1;

      // Reset state
      @(negedge clock);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_fallback",  32'(fallback),  32'd0);
      chk("rst_lfsr",      32'(dut.lfsr_state), 32'd1);

      // Full-range draws from 0x2A: 21 draws x 6 shifts = two periods of 63
      do_new_game(6'h2A);
      @(negedge clock);
      chk("seed_load", 32'(dut.lfsr_state), 32'h2A);
      for (int i = 0; i < 21; i++) begin
         draw(0, 1'b1);
         consume(int'($urandom_range(0, 2)), d);
         chk("full_range_nonzero", 32'(d != 0), 32'd1);
      end
      @(negedge clock);
      chk("period_return", 32'(dut.lfsr_state), 32'h2A);

      // Zero seed maps to default; first draw matches hand-derived state 000011
      do_new_game(0);
      @(negedge clock);
      chk("zero_seed", 32'(dut.lfsr_state), 32'd1);
      draw(0, 1'b1);
      consume(0, d);
      chk("golden_6_shifts", 32'(d), 32'd3);

      // limit=1 always yields 0
      for (int i = 0; i < 10; i++) begin
         draw(1, 1'b1);
         consume(int'($urandom_range(0, 1)), d);
         chk("limit1_zero", 32'(d), 32'd0);
      end

      // limit=40 bulk draws
      for (int i = 0; i < 1000; i++) begin
         draw(40, 1'b1);
         consume(int'($urandom_range(0, 1)), d);
         chk("limit40_range", 32'(d < 40), 32'd1);
      end

      // Random limits and reseeds
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 15) == 0) do_new_game(int'($urandom_range(0, 63)));
         draw(int'($urandom_range(0, 63)), 1'b1);
         consume(int'($urandom_range(0, 3)), d);
      end

      // Forced fallback: pick a seed whose four candidates all reject limit=5
      save  = m_lfsr;
      fseed = 0;
      for (int s = 1; s < 64; s++) begin
         m_lfsr = s;
         model_draw(5, fd, ff, ft);
         if (ff && fseed == 0) fseed = s;
      end
      m_lfsr = save;
      chk("fallback_seed_found", 32'(fseed != 0), 32'd1);
      do_new_game(fseed);
      draw(5, 1'b1);
      consume(0, d);
      chk("fallback_flag", 32'(last_fb), 32'd1);
      chk("fallback_range", 32'(d < 5), 32'd1);

      // Back-pressure: hold rsp_ready low for 10 cycles
      draw(20, 1'b1);
      wait_rsp();
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("hold_data",      32'(rsp_data),  32'(last_exp_data));
         chk("hold_valid",     32'(rsp_valid), 32'd1);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_lfsr",      32'(dut.lfsr_state), 32'(m_lfsr));
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
      @(negedge clock);
      chk("release_idle",  32'(req_ready), 32'd1);
      chk("release_valid", 32'(rsp_valid), 32'd0);

      // new_game mid-STEP discards the draw
      draw(30, 1'b0);
      repeat (2) @(negedge clock);
      do_new_game(6'h2B);
      chk("abort_step_valid", 32'(rsp_valid), 32'd0);
      chk("abort_step_lfsr",  32'(dut.lfsr_state), 32'h2B);
      repeat (40) @(negedge clock);
      chk("abort_step_quiet", 32'(rsp_valid), 32'd0);

      // new_game in HOLD drops rsp_valid
      draw(30, 1'b1);
      wait_rsp();
      do_new_game(6'h11);
      chk("abort_hold_valid", 32'(rsp_valid), 32'd0);
      chk("abort_hold_lfsr",  32'(dut.lfsr_state), 32'h11);
      repeat (20) @(negedge clock);
      chk("abort_hold_quiet", 32'(rsp_valid), 32'd0);

      // Async reset mid-STEP
      draw(30, 1'b0);
      repeat (2) @(negedge clock);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_lfsr",  32'(dut.lfsr_state), 32'd1);
      m_lfsr = 1;
      @(negedge clock);
      rst_n = 1'b1;
      repeat (40) @(negedge clock);
      chk("rst_mid_quiet", 32'(rsp_valid), 32'd0);

      // Recovery draw after reset
      draw(0, 1'b1);
      consume(0, d);
      chk("post_reset_golden", 32'(d), 32'd3);

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
